// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), frame totals, coordinate type and decode helper.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Half-open window test used for both sync pulses.
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Wrapping counter 0..TOTAL-1 with terminal-count flag and exposed next-state value.
module vga_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = H_TOTAL
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic [COORD_W-1:0] count_next,
    output logic               tc
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    // >= so an out-of-range count still wraps to 0 on the next enabled step.
    assign tc = (count >= LAST);

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = tc ? '0 : count + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/coordinate generator. Define VGA_SYNC_DELAY_EN to delay hs/vs one extra clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
)(
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               frame_start,
    output logic               frame_done
);

    localparam int H_TOTAL_CFG = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_CFG = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t h_count, h_next;
    coord_t v_count, v_next;
    logic   h_tc, v_tc;

    logic hs_p1, vs_p1, blank_p1, frame_start_p1, frame_done_p1;

    vga_counter #(.TOTAL(H_TOTAL_CFG)) u_hcnt (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (1'b1),
        .count      (h_count),
        .count_next (h_next),
        .tc         (h_tc)
    );

    vga_counter #(.TOTAL(V_TOTAL_CFG)) u_vcnt (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (h_tc),
        .count      (v_count),
        .count_next (v_next),
        .tc         (v_tc)
    );

    // Stage p1: decode from next-state counts so flags line up with the registered counts.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_p1          <= 1'b1;
            vs_p1          <= 1'b1;
            blank_p1       <= 1'b0;
            frame_start_p1 <= 1'b0;
            frame_done_p1  <= 1'b0;
        end else begin
            hs_p1          <= !in_window(h_next, HS_START, HS_END);
            vs_p1          <= !in_window(v_next, VS_START, VS_END);
            blank_p1       <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
            frame_start_p1 <= h_tc && v_tc;
            frame_done_p1  <= h_tc && (v_next == V_VIS_C);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_p2, vs_p2;

    // Stage p2: sync only, for sinks that register RGB one clock after the coordinates.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_p2 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    assign hs = hs_p2;
    assign vs = vs_p2;
`else
    assign hs = hs_p1;
    assign vs = vs_p1;
`endif

    assign blank       = blank_p1;
    assign frame_start = frame_start_p1;
    assign frame_done  = frame_done_p1;
    assign DrawX       = h_count;
    assign DrawY       = v_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: reduced-timing DUT under random resets vs. arithmetic model, plus default-timing DUT with pinned values.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hsy; int hb;
        int vv; int vf; int vsy; int vb;
    } timing_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       fd;
        logic [9:0] x;
        logic [9:0] y;
    } vga_out_t;

    localparam timing_t TA = '{hv:16, hf:4, hsy:6, hb:4, vv:10, vf:2, vsy:2, vb:3};
    localparam timing_t TB = '{hv:640, hf:16, hsy:96, hb:48, vv:480, vf:10, vsy:2, vb:33};

`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 1;
`else
    localparam int SD = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic hs_a, vs_a, blank_a, fs_a, fd_a;
    logic hs_b, vs_b, blank_b, fs_b, fd_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    int tests = 0;
    int fails = 0;

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_a (
        .vga_clk(clk), .reset_n(rst_a), .hs(hs_a), .vs(vs_a), .blank(blank_a),
        .DrawX(x_a), .DrawY(y_a), .frame_start(fs_a), .frame_done(fd_a)
    );

    vga_timing_gen dut_b (
        .vga_clk(clk), .reset_n(rst_b), .hs(hs_b), .vs(vs_b), .blank(blank_b),
        .DrawX(x_b), .DrawY(y_b), .frame_start(fs_b), .frame_done(fd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Is sync asserted at clock number t after release (t>=1)?
    function automatic void sync_at(input timing_t p, input longint t, output bit hlow, output bit vlow);
        longint ht, vt, n, x, y;
        ht = p.hv + p.hf + p.hsy + p.hb;
        vt = p.vv + p.vf + p.vsy + p.vb;
        n = t % (ht * vt);
        x = n % ht;
        y = n / ht;
        hlow = (x >= p.hv + p.hf) && (x < p.hv + p.hf + p.hsy);
        vlow = (y >= p.vv + p.vf) && (y < p.vv + p.vf + p.vsy);
    endfunction

    function automatic vga_out_t model(input timing_t p, input longint t, input bit in_rst);
        vga_out_t o;
        longint ht, vt, n, x, y;
        bit hl, vl;
        o = '{hs:1'b1, vs:1'b1, blank:1'b0, fs:1'b0, fd:1'b0, x:10'd0, y:10'd0};
        if (in_rst || t == 0) return o;
        ht = p.hv + p.hf + p.hsy + p.hb;
        vt = p.vv + p.vf + p.vsy + p.vb;
        n = t % (ht * vt);
        x = n % ht;
        y = n / ht;
        o.x = 10'(x);
        o.y = 10'(y);
        o.blank = (x < p.hv) && (y < p.vv);
        o.fs = (x == 0) && (y == 0);
        o.fd = (x == 0) && (y == p.vv);
        if (t - SD >= 1) begin
            sync_at(p, t - SD, hl, vl);
            o.hs = !hl;
            o.vs = !vl;
        end
        return o;
    endfunction

    longint ta = 0, tb = 0;
    always @(posedge clk) begin
        ta <= rst_a ? ta + 1 : 0;
        tb <= rst_b ? tb + 1 : 0;
    end

    int  period, vslow, fdn;
    bit  seen = 0;

    always @(negedge clk) begin
        vga_out_t e;
        e = model(TA, ta, !rst_a);
        check("a_x", 32'(x_a), 32'(e.x));
        check("a_y", 32'(y_a), 32'(e.y));
        check("a_hs", 32'(hs_a), 32'(e.hs));
        check("a_vs", 32'(vs_a), 32'(e.vs));
        check("a_blank", 32'(blank_a), 32'(e.blank));
        check("a_frame_start", 32'(fs_a), 32'(e.fs));
        check("a_frame_done", 32'(fd_a), 32'(e.fd));
        if (!rst_a) begin
            seen = 0;
        end else if (fs_a) begin
            if (seen) begin
                check("a_frame_period", 32'(period), 32'd510);
                check("a_vs_low_clocks", 32'(vslow), 32'd60);
                check("a_frame_done_per_frame", 32'(fdn), 32'd1);
            end
            seen = 1;
            period = 1;
            vslow = vs_a ? 0 : 1;
            fdn = fd_a ? 1 : 0;
        end else begin
            period++;
            vslow += vs_a ? 0 : 1;
            fdn += fd_a ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        vga_out_t e;
        e = model(TB, tb, !rst_b);
        check("b_x", 32'(x_b), 32'(e.x));
        check("b_y", 32'(y_b), 32'(e.y));
        check("b_hs", 32'(hs_b), 32'(e.hs));
        check("b_vs", 32'(vs_b), 32'(e.vs));
        check("b_blank", 32'(blank_b), 32'(e.blank));
        check("b_frame_start", 32'(fs_b), 32'(e.fs));
        check("b_frame_done", 32'(fd_b), 32'(e.fd));
        if (!rst_b) begin
            check("pin_rst_x", 32'(x_b), 32'd0);
            check("pin_rst_y", 32'(y_b), 32'd0);
            check("pin_rst_blank", 32'(blank_b), 32'd0);
            check("pin_rst_hs", 32'(hs_b), 32'd1);
        end
        if (tb == 1) begin
            check("pin_rel_x", 32'(x_b), 32'd1);
            check("pin_rel_blank", 32'(blank_b), 32'd1);
            check("pin_rel_fs", 32'(fs_b), 32'd0);
        end
        if (tb == 639) check("pin_blank_639", 32'(blank_b), 32'd1);
        if (tb == 640) check("pin_blank_640", 32'(blank_b), 32'd0);
        if (tb == 655 + SD) check("pin_hs_before", 32'(hs_b), 32'd1);
        if (tb == 656 + SD) check("pin_hs_fall", 32'(hs_b), 32'd0);
        if (tb == 751 + SD) check("pin_hs_last", 32'(hs_b), 32'd0);
        if (tb == 752 + SD) check("pin_hs_rise", 32'(hs_b), 32'd1);
        if (tb == 799) check("pin_x_799", 32'(x_b), 32'd799);
        if (tb == 800) begin
            check("pin_wrap_x", 32'(x_b), 32'd0);
            check("pin_wrap_y", 32'(y_b), 32'd1);
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (1100) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(200, 1500)) @(posedge clk);
            #($urandom_range(1, 3));
            rst_a = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
            rst_a = 1'b1;
        end
        repeat (1200) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL take parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 SHALL take parameter H_FRONT, default 16, meaning horizontal front porch in clocks.
REQ-003 SHALL take parameter H_SYNC, default 96, meaning hsync pulse width in clocks.
REQ-004 SHALL take parameter H_BACK, default 48, meaning horizontal back porch in clocks.
REQ-005 SHALL take parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-006 SHALL take parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 SHALL take parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 SHALL take parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have port vga_clk, input, 1 bit: pixel clock; the block has one clock and all state is on its rising edge.
REQ-010 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port hs, output, 1 bit: horizontal sync, active low.
REQ-012 SHALL have port vs, output, 1 bit: vertical sync, active low.
REQ-013 SHALL have port blank, output, 1 bit: high means active video and the pixel is drawn; low means blanking.
REQ-014 SHALL have port DrawX, output, 10 bits: current horizontal count.
REQ-015 SHALL have port DrawY, output, 10 bits: current vertical count.
REQ-016 SHALL have port frame_start, output, 1 bit: one-cycle pulse at (0,0).
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse at (0,V_VISIBLE), the start of vertical blanking, for game-logic update.

Function
REQ-018 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 SHALL increment DrawX every clock; when DrawX = H_TOTAL-1, DrawX SHALL wrap to 0 and DrawY SHALL increment on the same edge.
REQ-020 SHALL wrap DrawY to 0 when DrawX = H_TOTAL-1 and DrawY = V_TOTAL-1; both counters wrap on the same edge.
REQ-021 SHALL register hs, vs, blank, frame_start and frame_done, each decoded from next-state counts so it is aligned with the DrawX/DrawY presented in the same cycle (zero relative latency).
REQ-022 SHALL drive hs low iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-023 SHALL drive vs low iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines.
REQ-024 SHALL drive blank high iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-025 SHALL keep counters out of the range H_TOTAL/V_TOTAL and above; compare with >= on the terminal count so a corrupted count recovers to 0 within one line or one frame.

Reset
REQ-026 SHALL, while reset_n is low, force DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, frame_done=0, regardless of the clock.
REQ-027 SHALL, on the first rising edge after reset_n deasserts, present DrawX=1; the (0,0) cycle at reset exit SHALL NOT raise frame_start, so the first frame_start occurs at the next frame wrap.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame with no partial pulses, and restart per REQ-027.

Configuration
REQ-029 SHALL, with macro VGA_SYNC_DELAY_EN defined, delay hs and vs by one extra register stage (reset value 1) to match consumers that register RGB one cycle after DrawX/DrawY; blank, DrawX, DrawY and the pulses are not delayed.
REQ-030 SHALL, without VGA_SYNC_DELAY_EN, keep hs and vs aligned per REQ-021.

Structure
REQ-031 SHALL place the default timing constants, H_TOTAL/V_TOTAL and the 10-bit coordinate typedef in shared package vga_pkg.
REQ-032 SHALL implement the counters in one sub-module, vga_counter (wrapping counter with terminal-count output), instantiated twice with the horizontal terminal count used as the vertical enable.

Verification
REQ-033 SHALL cover reset release: reset_n low 5 clocks then high -> DrawX=0,DrawY=0,blank=0 during reset; first edge after release DrawX=1, blank=1, frame_start=0.
REQ-034 SHALL cover the hsync window: on line 10 -> hs=1 at DrawX=655, hs=0 at 656..751, hs=1 at 752; blank=0 from DrawX=640.
REQ-035 SHALL cover line and frame wrap: (799,9) -> (0,10); (799,524) -> (0,0) with frame_start=1 for exactly one cycle; frame_done=1 only at (0,480).
REQ-036 SHALL cover vsync: vs=0 for DrawY 490..491, i.e. exactly 1600 clocks per frame; 420000 clocks per frame in total.
REQ-037 SHALL cover reset mid-frame at (300,200) -> outputs return to reset values asynchronously, and no frame_done before the full 480 lines following release.
REQ-038 SHALL cover the build with VGA_SYNC_DELAY_EN -> hs falls at DrawX=657 and rises at 753, while blank is unchanged relative to the default build.
